// File: rtl/chan_512_snap_capture.sv
// chan_512_snap_capture
//   Snapshot capture engine driven by the startBuffer software register word.
//   A rising edge on start (bit 0) arms the engine; with sync_en (bit 1) set it
//   waits for the channelizer frame sync, otherwise it starts on the next cycle.
//   It then writes L valid samples into the snapshot BRAM at addresses 0..L-1,
//   where L is len (bits [4+ADDR_W-1:4]), or 2^ADDR_W when len is 0.
//   abort (bit 2) is level-sensitive and returns the engine to IDLE.
//
// Ports
//   user_clk, user_rst_n : clock, asynchronous active-low reset
//   start_word           : startBuffer register value (user_clk domain)
//   sync_in              : one-cycle frame-sync pulse
//   din, din_valid       : channel sample stream
//   bram_addr/din/we     : registered snapshot BRAM write port
//   busy                 : ARMED or CAPTURE
//   done                 : capture finished
//   wr_count             : samples written in the current/last capture
module chan_512_snap_capture #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       start_word,
  input  logic              sync_in,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              start_d;
  logic              sync_en_q;
  logic              sync_seen;
  logic [ADDR_W:0]   len_q;

  logic              start_bit;
  logic              sync_en_in;
  logic              abort;
  logic [ADDR_W-1:0] len_in;
  logic [ADDR_W:0]   len_full;
  logic              start_edge;
  logic              last;
  logic              accept;
  logic              arm;
  logic              unused_start_bits;

  assign start_bit  = start_word[0];
  assign sync_en_in = start_word[1];
  assign abort      = start_word[2];
  assign len_in     = start_word[4+ADDR_W-1:4];
  assign unused_start_bits = start_word[3];

  assign start_edge = start_bit & ~start_d;

  // len == 0 encodes the full BRAM depth
  always_comb begin
    len_full = {1'b0, len_in};
    if (len_in == '0) len_full = {1'b1, {ADDR_W{1'b0}}};
  end

  // The sample being accepted now is the final one of the capture
  assign last = (wr_count == len_q - 1'b1);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    arm       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            arm       = 1'b1;
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (!sync_en_q) begin
            state_nxt = CAPTURE;
          end else if (sync_in || sync_seen) begin
            // sample coincident with the sync is the first one captured
            accept    = din_valid;
            state_nxt = CAPTURE;
          end
          if (accept && last) state_nxt = DONE;
        end
        CAPTURE: begin
          accept = din_valid;
          if (accept && last) state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      start_d   <= 1'b0;
      sync_en_q <= 1'b0;
      sync_seen <= 1'b0;
      len_q     <= '0;
      wr_count  <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
      bram_we   <= 1'b0;
    end else begin
      start_d <= start_bit;
      bram_we <= accept;
      if (accept) begin
        bram_addr <= wr_count[ADDR_W-1:0];
        bram_din  <= din;
        wr_count  <= wr_count + 1'b1;
      end
      if (state == ARMED && !abort && sync_in) sync_seen <= 1'b1;
      if (arm) begin
        len_q     <= len_full;
        sync_en_q <= sync_en_in;
        wr_count  <= '0;
        sync_seen <= 1'b0;
      end
    end
  end

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_chan_512_snap_capture.sv
module tb_chan_512_snap_capture;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [31:0]       start_word;
  logic              sync_in;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  chan_512_snap_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .start_word (start_word),
    .sync_in    (sync_in),
    .din        (din),
    .din_valid  (din_valid),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_we    (bram_we),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned exp_addr;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] mk(bit s, bit se, bit ab, int unsigned len);
    logic [31:0] w;
    w = '0;
    w[0] = s;
    w[1] = se;
    w[2] = ab;
    w[13:4] = len[9:0];
    return w;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of sample input; push=1 means this sample must be written
  task automatic drv(bit v, int unsigned d, bit push);
    din_valid = v;
    din       = d;
    if (push) begin
      exp_q.push_back('{addr: exp_addr, data: d});
      exp_addr++;
    end
    step();
  endtask

  task automatic q_empty(string name);
    chk(name, exp_q.size(), 0);
  endtask

  // monitor: every BRAM write must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n && bram_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h required no write",
                 bram_addr, bram_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bram_addr != e.addr[ADDR_W-1:0] || bram_din != e.data) begin
          n_err++;
          $display("FAIL write: got addr=0x%0h data=0x%0h required addr=0x%0h data=0x%0h",
                   bram_addr, bram_din, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    start_word = '0;
    sync_in    = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    exp_addr   = 0;

    // reset state
    #3;
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_din", bram_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // basic capture, len=4, no sync: IDLE and ARMED cycles swallow A0, A1
    exp_addr = 0;
    start_word = mk(1, 0, 0, 4);
    drv(1, 'hA0, 0);
    chk("t1_busy_armed", busy, 1);
    drv(1, 'hA1, 0);
    drv(1, 'hA2, 1);
    drv(1, 'hA3, 1);
    drv(1, 'hA4, 1);
    drv(1, 'hA5, 1);
    drv(0, 0, 0);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_count", wr_count, 4);
    q_empty("t1_queue");

    // synced capture, len=3
    start_word = mk(0, 1, 0, 3);
    drv(0, 0, 0);
    exp_addr = 0;
    start_word = mk(1, 1, 0, 3);
    for (int i = 0; i < 10; i++) drv(1, 'h100 + i, 0);
    chk("t2_busy_wait", busy, 1);
    chk("t2_count_wait", wr_count, 0);
    sync_in = 1'b1;
    drv(1, 'h55, 1);
    sync_in = 1'b0;
    drv(1, 'h56, 1);
    drv(1, 'h57, 1);
    drv(1, 'h58, 0);
    chk("t2_done", done, 1);
    chk("t2_count", wr_count, 3);
    q_empty("t2_queue");

    // valid gaps, len=5
    start_word = mk(0, 0, 0, 5);
    drv(0, 0, 0);
    exp_addr = 0;
    start_word = mk(1, 0, 0, 5);
    drv(0, 0, 0);
    drv(0, 0, 0);
    begin
      bit pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
      for (int i = 0; i < 8; i++) drv(pat[i], 'h30 + i, pat[i]);
    end
    drv(0, 0, 0);
    chk("t3_done", done, 1);
    chk("t3_count", wr_count, 5);
    q_empty("t3_queue");

    // full depth, len=0
    start_word = mk(0, 0, 0, 0);
    drv(0, 0, 0);
    exp_addr = 0;
    start_word = mk(1, 0, 0, 0);
    drv(0, 0, 0);
    drv(0, 0, 0);
    for (int i = 0; i < 1024; i++) drv(1, 'h1000 + i, 1);
    for (int i = 0; i < 3; i++) drv(1, 'hDEAD, 0);
    din_valid = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_count", wr_count, 1024);
    q_empty("t4_queue");

    // abort at sample 7 of 16
    start_word = mk(0, 0, 0, 16);
    drv(0, 0, 0);
    exp_addr = 0;
    start_word = mk(1, 0, 0, 16);
    drv(0, 0, 0);
    drv(0, 0, 0);
    for (int i = 0; i < 7; i++) drv(1, 'h700 + i, 1);
    start_word = mk(1, 0, 1, 16);
    drv(1, 'h99, 0);
    drv(0, 0, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_count", wr_count, 7);
    // start edge while abort held is ignored
    start_word = mk(0, 0, 1, 16);
    drv(0, 0, 0);
    start_word = mk(1, 0, 1, 16);
    drv(1, 'h98, 0);
    drv(1, 'h97, 0);
    chk("t5_ign_busy", busy, 0);
    chk("t5_ign_count", wr_count, 7);
    // clear abort, restart from address 0
    start_word = mk(0, 0, 0, 2);
    drv(0, 0, 0);
    exp_addr = 0;
    start_word = mk(1, 0, 0, 2);
    drv(0, 0, 0);
    chk("t5_rearm_busy", busy, 1);
    chk("t5_rearm_count", wr_count, 0);
    drv(0, 0, 0);
    drv(1, 'hB0, 1);
    drv(1, 'hB1, 1);
    drv(0, 0, 0);
    chk("t5_done", done, 1);
    chk("t5_count2", wr_count, 2);
    q_empty("t5_queue");

    // start held high after DONE does not re-arm
    for (int i = 0; i < 5; i++) drv(1, 'hC0 + i, 0);
    chk("t6_held_done", done, 1);
    chk("t6_held_busy", busy, 0);
    chk("t6_held_count", wr_count, 2);

    // asynchronous reset mid-capture
    start_word = mk(0, 0, 0, 8);
    drv(0, 0, 0);
    exp_addr = 0;
    start_word = mk(1, 0, 0, 8);
    drv(0, 0, 0);
    drv(0, 0, 0);
    drv(1, 'hD0, 1);
    drv(1, 'hD1, 1);
    drv(1, 'hD2, 0);
    chk("t6_we_before_rst", bram_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_we", bram_we, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", wr_count, 0);
    chk("t6_rst_addr", bram_addr, 0);
    chk("t6_rst_din", bram_din, 0);
    din_valid  = 1'b0;
    start_word = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    q_empty("t6_queue");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chan_512_snap_capture.md
Name: chan_512_snap_capture

Overview:
- Downstream consumer of the startBuffer software register word, in the user_clk domain.
- Decodes the word into start, sync-enable, abort and length fields.
- Arms on a start rising edge, optionally waits for the channelizer frame sync, then writes a programmed number of valid 32-bit channel samples into a snapshot BRAM.
- Reports busy, done and a sample count for software readback.

Parameters:
- ADDR_W, 10, BRAM address width; maximum capture depth is 2^ADDR_W samples.
- DATA_W, 32, sample and BRAM data width.

Ports:
- user_clk  in  1  fabric/user clock; everything is synchronous to its rising edge.
- user_rst_n  in  1  asynchronous active-low reset.
- start_word  in  32  startBuffer register value (user_data_out), already in the user_clk domain.
- sync_in  in  1  one-cycle channelizer frame-sync pulse.
- din  in  DATA_W  channel sample data.
- din_valid  in  1  din qualifier.
- bram_addr  out  ADDR_W  snapshot BRAM write address.
- bram_din  out  DATA_W  snapshot BRAM write data.
- bram_we  out  1  snapshot BRAM write enable.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDR_W+1  number of samples written in the current or last capture.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal start_d, len_q and sync_seen are 0.
- start_word fields:
  - bit0 start: acts on its rising edge only; start_d is a registered copy of bit0 and an edge is bit0 & ~start_d.
  - bit1 sync_en.
  - bit2 abort: level-sensitive.
  - bits [4+ADDR_W-1:4] len.
  - All other bits are ignored.
- Capture length L: latched on the start edge. L = 2^ADDR_W if len == 0, else L = len.
- IDLE:
  - On start edge: latch L and sync_en, clear wr_count to 0, go to ARMED.
- ARMED:
  - If sync_en = 0: go to CAPTURE on the next cycle.
  - If sync_en = 1: set sync_seen on sync_in; go to CAPTURE in the cycle after sync_in.
  - The first din_valid sample in the same cycle as sync_in or later is written at address 0. It is accepted in ARMED when sync_in or sync_seen is 1.
- CAPTURE: each din_valid cycle writes one sample.
  - Outputs are registered: a sample accepted in cycle t gives bram_we=1, bram_din=din and bram_addr=wr_count(t) in cycle t+1.
  - wr_count increments in cycle t+1.
  - When the write of sample L-1 is issued, go to DONE. The write of sample L-1 appears in the first DONE cycle.
  - din_valid gaps insert no writes, and the address does not advance.
- DONE:
  - done=1 and busy=0; wr_count holds L.
  - A start edge clears done, relatches the fields and goes to ARMED in one step.
- Address range: addresses stay in 0..L-1 and never wrap; wr_count saturates at L.
- Abort: abort=1 in any state forces IDLE on the next cycle.
  - bram_we is forced to 0 that cycle; done=0 and busy=0.
  - wr_count holds the partial count.
  - Abort takes priority over a start edge in the same cycle.
  - Start edges are ignored while abort=1.
- Edges ignored while active: start edges in ARMED or CAPTURE are ignored, and nothing is relatched.
- Falling start: a falling edge of start has no effect. Software must write start=0 before the next capture.
- Simultaneous sync_in and din_valid in ARMED: that sample is captured as address 0.
- Sync in CAPTURE: sync_in in CAPTURE is ignored.
- Mid-operation reset: an asynchronous reset mid-capture returns to IDLE immediately and drops bram_we the same instant.

Test Plan:
- Basic capture with len=4, sync_en=0:
  - Stimulus: start 0->1, then continuous din_valid with din=0xA0..0xA5.
  - Required: exactly 4 writes, addr 0..3, data 0xA0..0xA3 (or offset by arming latency, as computed by the model), then done=1, busy=0, wr_count=4.
- Synced capture with len=3, sync_en=1:
  - Stimulus: continuous valid data; sync_in pulses with din=0x55 valid, 10 cycles after arm.
  - Required: addr 0 is written with 0x55, then exactly 2 more writes; no writes occur before the sync.
- Valid gaps with len=5:
  - Stimulus: din_valid pattern 1,0,0,1,1,0,1,1.
  - Required: 5 writes with contiguous addresses 0..4, and bram_we follows din_valid delayed by 1.
- Full depth with len=0, ADDR_W=10:
  - Required: 1024 writes, last addr 0x3FF, wr_count=1024, no write to address 0 after the end.
- Abort and re-start:
  - Stimulus: abort=1 at sample 7 of a 16-sample capture.
  - Required: IDLE, wr_count=7, done=0.
  - Stimulus: a start edge while abort=1.
  - Required: it is ignored.
  - Stimulus: clear abort, then start 0->1.
  - Required: the capture restarts from addr 0.
- Held start and reset:
  - Stimulus: start held at 1 after DONE.
  - Required: no re-arm.
  - Stimulus: user_rst_n low mid-capture.
  - Required: outputs go to 0 asynchronously.
